second_counter_ctrl: RTL and testbench

//  Run/pause/clear controller for the seconds-counter datapath.
//  - Owns the one-second prescaler; it replaces the free-running divided clock with a single-cycle tick enable in the clk_in domain.
//  - Sequences a BCD MM:SS counter from user command pulses.
//  - Sits between debounced button pulses and the 7-segment display driver.

---
 rtl/second_counter_pkg.sv | 16 +
 rtl/second_counter_ctrl_if.sv | 27 ++
 rtl/bcd_mod_counter.sv | 39 +++
 rtl/second_counter_ctrl.sv | 146 ++++++++++++++
 tb/tb_second_counter_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/second_counter_pkg.sv
// Shared types and digit limits for the MM:SS seconds-counter controller.
package second_counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   localparam int BCD_MAX      = 9;
   localparam int SEC_TENS_MAX = 5;
   localparam int MIN_TENS_MAX = 5;
   localparam int BCD_W        = 4;
   localparam int TENS_W       = 3;

endpackage

// File: rtl/second_counter_ctrl_if.sv
// Command pulses in, tick/status and MM:SS digits out, for second_counter_ctrl.
interface second_counter_ctrl_if;
   import second_counter_pkg::*;

   logic              start_p;
   logic              stop_p;
   logic              clear_p;
   logic              lap_p;
   logic              tick_o;
   logic              wrap_o;
   logic              running_o;
   logic [BCD_W-1:0]  sec_ones;
   logic [TENS_W-1:0] sec_tens;
   logic [BCD_W-1:0]  min_ones;
   logic [TENS_W-1:0] min_tens;

   modport master (
      output start_p, stop_p, clear_p, lap_p,
      input  tick_o, wrap_o, running_o, sec_ones, sec_tens, min_ones, min_tens
   );

   modport slave (
      input  start_p, stop_p, clear_p, lap_p,
      output tick_o, wrap_o, running_o, sec_ones, sec_tens, min_ones, min_tens
   );

endinterface

// File: rtl/bcd_mod_counter.sv
// Single modulo-(MAX+1) digit; carry is combinational so digits chain within one edge.
module bcd_mod_counter #(
   parameter int MAX = 9,
   parameter int W   = 4
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] out,
   output logic         carry
);

   logic [W-1:0] out_q;
   logic [W-1:0] out_d;
   logic         at_max;

   assign at_max = (out_q == W'(MAX));
   assign carry  = inc && at_max;
   assign out    = out_q;

   always_comb begin
      out_d = out_q;
      if (clr) begin
         out_d = '0;
      end else if (inc) begin
         out_d = at_max ? '0 : out_q + W'(1);
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

endmodule

// File: rtl/second_counter_ctrl.sv
// Run/pause/clear sequencer with one-second prescaler and BCD MM:SS digits.
// Optional lap-hold display snapshot is built when LAP_HOLD_EN is defined.
//
// state | meaning
// IDLE  | stopped and cleared; prescaler held at 0
// RUN   | prescaler counting, digits advance on each terminal count
// PAUSE | prescaler and digits frozen; resume finishes the partial second
module second_counter_ctrl
   import second_counter_pkg::*;
#(
   parameter int DIV = 100_000_000
) (
   input  logic                 clk_in,
   input  logic                 rst,
   second_counter_ctrl_if.slave bus
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(DIV - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  presc_q, presc_d;
   logic              tick_q, tick_d;
   logic              wrap_q, wrap_d;
   logic              clr_cnt;

   logic [BCD_W-1:0]  sec_ones_live;
   logic [TENS_W-1:0] sec_tens_live;
   logic [BCD_W-1:0]  min_ones_live;
   logic [TENS_W-1:0] min_tens_live;
   logic              c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;

   // clear outranks stop, stop outranks start; a blocked start is dropped
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      clr_cnt = 1'b0;
      if (bus.clear_p) begin
         state_d = IDLE;
         presc_d = '0;
         clr_cnt = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               presc_d = '0;
               if (!bus.stop_p && bus.start_p) state_d = RUN;
            end
            RUN: begin
               if (bus.stop_p) begin
                  state_d = PAUSE;
               end else if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
               end else begin
                  presc_d = presc_q + CNT_W'(1);
               end
            end
            PAUSE: begin
               if (!bus.stop_p && bus.start_p) state_d = RUN;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign wrap_d = c_min_tens;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         presc_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   bcd_mod_counter #(.MAX(BCD_MAX), .W(BCD_W)) u_sec_ones (
      .clk_in(clk_in), .rst(rst), .inc(tick_d), .clr(clr_cnt),
      .out(sec_ones_live), .carry(c_sec_ones)
   );

   bcd_mod_counter #(.MAX(SEC_TENS_MAX), .W(TENS_W)) u_sec_tens (
      .clk_in(clk_in), .rst(rst), .inc(c_sec_ones), .clr(clr_cnt),
      .out(sec_tens_live), .carry(c_sec_tens)
   );

   bcd_mod_counter #(.MAX(BCD_MAX), .W(BCD_W)) u_min_ones (
      .clk_in(clk_in), .rst(rst), .inc(c_sec_tens), .clr(clr_cnt),
      .out(min_ones_live), .carry(c_min_ones)
   );

   bcd_mod_counter #(.MAX(MIN_TENS_MAX), .W(TENS_W)) u_min_tens (
      .clk_in(clk_in), .rst(rst), .inc(c_min_ones), .clr(clr_cnt),
      .out(min_tens_live), .carry(c_min_tens)
   );

   assign bus.tick_o    = tick_q;
   assign bus.wrap_o    = wrap_q;
   assign bus.running_o = (state_q == RUN);

`ifdef LAP_HOLD_EN
   logic              hold_q;
   logic [BCD_W-1:0]  snap_sec_ones_q;
   logic [TENS_W-1:0] snap_sec_tens_q;
   logic [BCD_W-1:0]  snap_min_ones_q;
   logic [TENS_W-1:0] snap_min_tens_q;

   // snapshot takes the count shown before the lap edge, not a same-edge tick
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         hold_q          <= 1'b0;
         snap_sec_ones_q <= '0;
         snap_sec_tens_q <= '0;
         snap_min_ones_q <= '0;
         snap_min_tens_q <= '0;
      end else if (bus.clear_p) begin
         hold_q <= 1'b0;
      end else if (bus.lap_p) begin
         hold_q          <= ~hold_q;
         snap_sec_ones_q <= sec_ones_live;
         snap_sec_tens_q <= sec_tens_live;
         snap_min_ones_q <= min_ones_live;
         snap_min_tens_q <= min_tens_live;
      end
   end

   assign bus.sec_ones = hold_q ? snap_sec_ones_q : sec_ones_live;
   assign bus.sec_tens = hold_q ? snap_sec_tens_q : sec_tens_live;
   assign bus.min_ones = hold_q ? snap_min_ones_q : min_ones_live;
   assign bus.min_tens = hold_q ? snap_min_tens_q : min_tens_live;
`else
   logic lap_unused;
   assign lap_unused   = bus.lap_p;
   assign bus.sec_ones = sec_ones_live;
   assign bus.sec_tens = sec_tens_live;
   assign bus.min_ones = min_ones_live;
   assign bus.min_tens = min_tens_live;
`endif

endmodule

// File: tb/tb_second_counter_ctrl.sv
// Directed bench for second_counter_ctrl at DIV=4; lap checks adapt to LAP_HOLD_EN.
module tb_second_counter_ctrl;
   localparam int DIV = 4;

   logic clk_in;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   second_counter_ctrl_if bus();

   second_counter_ctrl #(.DIV(DIV)) dut (
      .clk_in(clk_in),
      .rst   (rst),
      .bus   (bus)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic start;
      logic stop;
      logic clear;
      logic exp_tick;
      logic exp_run;
      int   exp_disp;
   } vec_t;

   vec_t vecs[26];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int disp();
      return int'(bus.min_tens) * 1000 + int'(bus.min_ones) * 100 +
             int'(bus.sec_tens) * 10 + int'(bus.sec_ones);
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic cmd(input logic s, input logic p, input logic c, input logic l);
      bus.start_p = s;
      bus.stop_p  = p;
      bus.clear_p = c;
      bus.lap_p   = l;
      step();
      bus.start_p = 1'b0;
      bus.stop_p  = 1'b0;
      bus.clear_p = 1'b0;
      bus.lap_p   = 1'b0;
   endtask

   // returns in the cycle where the n-th tick is visible
   task automatic wait_ticks(input int n, input string name);
      int seen   = 0;
      int budget = n * DIV + 2 * DIV + 4;
      while (seen < n && budget > 0) begin
         step();
         if (bus.tick_o) seen++;
         budget--;
      end
      chk({name, "_ticks"}, seen, n);
   endtask

   initial begin
      int tcount;
      int exp_val;

      // start, stop, clear, tick, run, MMSS (checked in the cycle after the row)
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4};
      vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4};
      vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4};
      vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4};
      vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5};
      vecs[24] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      vecs[25] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};

      bus.start_p = 1'b0;
      bus.stop_p  = 1'b0;
      bus.clear_p = 1'b0;
      bus.lap_p   = 1'b0;
      rst = 1'b1;
      step();
      step();
      chk("rst_disp", disp(), 0);
      chk("rst_tick", int'(bus.tick_o), 0);
      chk("rst_wrap", int'(bus.wrap_o), 0);
      chk("rst_run", int'(bus.running_o), 0);
      rst = 1'b0;
      step();
      step();
      chk("idle_run", int'(bus.running_o), 0);

      // start latency, steady ticks, pause/resume, ignored commands, clear
      for (int i = 0; i < 26; i++) begin
         cmd(vecs[i].start, vecs[i].stop, vecs[i].clear, 1'b0);
         chk($sformatf("vec%0d_tick", i), int'(bus.tick_o), int'(vecs[i].exp_tick));
         chk($sformatf("vec%0d_run", i), int'(bus.running_o), int'(vecs[i].exp_run));
         chk($sformatf("vec%0d_disp", i), disp(), vecs[i].exp_disp);
         chk($sformatf("vec%0d_wrap", i), int'(bus.wrap_o), 0);
      end

      // pause after a partial second, resume completes it
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      step();
      cmd(1'b0, 1'b1, 1'b0, 1'b0);
      chk("pause_run", int'(bus.running_o), 0);
      tcount = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.tick_o) tcount++;
      end
      chk("pause_no_tick", tcount, 0);
      chk("pause_disp", disp(), 0);
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      chk("resume_run", int'(bus.running_o), 1);
      chk("resume_t0", int'(bus.tick_o), 0);
      step();
      chk("resume_t1", int'(bus.tick_o), 0);
      step();
      chk("resume_t2", int'(bus.tick_o), 0);
      step();
      chk("resume_t3", int'(bus.tick_o), 1);
      chk("resume_disp", disp(), 1);

      // stop on the cycle a tick is due: no tick, prescaler held at DIV-1
      step();
      step();
      step();
      cmd(1'b0, 1'b1, 1'b0, 1'b0);
      chk("stopdue_tick", int'(bus.tick_o), 0);
      chk("stopdue_run", int'(bus.running_o), 0);
      chk("stopdue_disp", disp(), 1);
      tcount = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.tick_o) tcount++;
      end
      chk("stopdue_no_tick", tcount, 0);
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      chk("stopdue_r0", int'(bus.tick_o), 0);
      step();
      chk("stopdue_r1", int'(bus.tick_o), 1);
      chk("stopdue_r1_disp", disp(), 2);

      // all three commands together while a tick is due at 00:12
      cmd(1'b0, 1'b0, 1'b1, 1'b0);
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      wait_ticks(12, "combo");
      chk("combo_pre_disp", disp(), 12);
      step();
      step();
      step();
      cmd(1'b1, 1'b1, 1'b1, 1'b0);
      chk("combo_run", int'(bus.running_o), 0);
      chk("combo_disp", disp(), 0);
      chk("combo_tick", int'(bus.tick_o), 0);
      chk("combo_wrap", int'(bus.wrap_o), 0);
      step();
      chk("combo_tick2", int'(bus.tick_o), 0);
      chk("combo_run2", int'(bus.running_o), 0);

      // asynchronous reset at 00:07 while tick_o is high
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      wait_ticks(7, "arst");
      chk("arst_pre_disp", disp(), 7);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_disp", disp(), 0);
      chk("arst_tick", int'(bus.tick_o), 0);
      chk("arst_run", int'(bus.running_o), 0);
      step();
      rst = 1'b0;
      tcount = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.tick_o || bus.running_o) tcount++;
      end
      chk("arst_idle", tcount, 0);

      // carry chain through to full wrap
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      wait_ticks(9, "c9");
      chk("carry_0009", disp(), 9);
      wait_ticks(1, "c10");
      chk("carry_0010", disp(), 10);
      wait_ticks(50, "c100");
      chk("carry_0100", disp(), 100);
      wait_ticks(540, "c1000");
      chk("carry_1000", disp(), 1000);
      wait_ticks(2998, "c5958");
      chk("carry_5958", disp(), 5958);
      wait_ticks(1, "c5959");
      chk("carry_5959", disp(), 5959);
      chk("carry_5959_wrap", int'(bus.wrap_o), 0);
      wait_ticks(1, "cwrap");
      chk("wrap_disp", disp(), 0);
      chk("wrap_tick", int'(bus.tick_o), 1);
      chk("wrap_wrap", int'(bus.wrap_o), 1);
      step();
      chk("wrap_after", int'(bus.wrap_o), 0);

      // lap hold (live display when the feature is not built)
      cmd(1'b0, 1'b0, 1'b1, 1'b0);
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      wait_ticks(3, "lap3");
      chk("lap_pre", disp(), 3);
      cmd(1'b0, 1'b0, 1'b0, 1'b1);
      wait_ticks(5, "lap_run");
`ifdef LAP_HOLD_EN
      exp_val = 3;
`else
      exp_val = 8;
`endif
      chk("lap_held", disp(), exp_val);
      cmd(1'b0, 1'b0, 1'b0, 1'b1);
      chk("lap_release", disp(), 8);
      cmd(1'b0, 1'b0, 1'b0, 1'b1);
      wait_ticks(1, "lap_again");
`ifdef LAP_HOLD_EN
      exp_val = 8;
`else
      exp_val = 9;
`endif
      chk("lap_held2", disp(), exp_val);
      cmd(1'b0, 1'b0, 1'b1, 1'b0);
      chk("lap_clear", disp(), 0);
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      wait_ticks(1, "lap_post_clear");
      chk("lap_clear_hold", disp(), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
